mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port unified program/data RAM between the CPU instruction-fetch port and the load/store port.
- Also decodes the console MMIO word at CONSOLE_ADDR and forwards byte writes to a console sink over a valid/ready handshake.
- Sits between the cpu core and the RAM model or macro.
- Replaces the dual-read-port memory idealisation, so the core sees real fetch/data contention and stalls.

Parameters:
- AW, 32, byte-address width of both requester ports.
- MEM_WORDS, 65536, RAM depth in 32-bit words; RAM index = addr[log2(MEM_WORDS)+1:2].
- CONSOLE_ADDR, 32'h1000_0000, word address decoded as the console register.
- MAX_DSTREAK, 4, maximum consecutive data grants while a fetch is pending.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next posedge).
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch byte address (word-aligned).
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid (one cycle after i_gnt).
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request.
- d_we  in  4  byte write strobes; 0 = load.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid (one cycle after d_gnt of a load).
- d_rdata  out  32  load data.
- m_en  out  1  RAM enable.
- m_we  out  4  RAM byte strobes.
- m_addr  out  log2(MEM_WORDS)  RAM word index.
- m_wdata  out  32  RAM write data.
- m_rdata  in  32  RAM read data, registered, valid the cycle after m_en.
- con_valid  out  1  console byte valid.
- con_data  out  8  console byte (d_wdata[7:0]).
- con_ready  in  1  console sink accepts byte.

Behaviour:
- Reset values: all outputs 0. Internal state also clears: resp_owner=NONE, dstreak=0, grant state=IDLE.
- Grant is combinational on the current requests, at most one grant per cycle:
  - Data wins by default.
  - Fetch wins if i_req && dstreak==MAX_DSTREAK.
  - The loser sees gnt=0 and holds its request and payload stable until granted.
- dstreak counter:
  - +1 on each d_gnt while i_req=1.
  - Cleared on i_gnt or when i_req=0.
  - Saturates at MAX_DSTREAK.
- RAM path:
  - On a RAM grant, m_en=1 and m_addr, m_we, m_wdata are driven from the winner in the same cycle.
  - Fetch grants always drive m_we=0.
- resp_owner register records I, D or NONE for the granted read.
- Next cycle: the matching rvalid=1 with rdata=m_rdata; the other rvalid=0. Stores produce no rvalid.
- Console decode: d_addr[AW-1:2]==CONSOLE_ADDR[AW-1:2] bypasses RAM (m_en=0).
  - Store:
    - con_valid=1 for as long as d_req is held.
    - d_gnt=1 only in the cycle con_valid&&con_ready. A stall on con_ready=0 therefore stalls the core.
    - During that stall the RAM is free, so a pending fetch is granted in the same cycle.
  - Load: d_gnt immediately; next cycle d_rvalid=1, d_rdata=32'h0000_0000.
- Out-of-range RAM addresses wrap modulo MEM_WORDS; there is no error response.
- Simultaneous i_req and d_req to RAM: exactly one granted; the other waits ≥1 cycle.
- Reset mid-transaction:
  - Any pending rvalid is dropped; no rvalid appears in the cycle after reset is sampled low.
  - A con_valid in progress deasserts.

Decomposition:
- Shared package mem_pkg:
  - resp_owner enum {NONE, I, D}.
  - CONSOLE_ADDR and MEM_WORDS defaults.
  - Byte-strobe width constant.
- One natural sub-module, mem_arb_pick: combinational priority plus dstreak starvation counter, returning grant_i and grant_d. The remaining logic (decode, response routing, console handshake) stays in mem_arbiter.

Test Plan:
- Fetch only: i_req=1, i_addr=0x40 for 3 cycles, RAM[16]=0x00100073 -> i_gnt each cycle, i_rvalid one cycle later, i_rdata=0x00100073, d_rvalid never 1.
- Contention and starvation: i_req and d_req (loads) held continuously, MAX_DSTREAK=4 -> grant pattern D,D,D,D,I repeating; dstreak observed 0→4 then reset.
- Byte store and readback: store d_we=4'b0010, d_addr=0x104, d_wdata=0x0000AB00 onto word 0x11223344 -> subsequent load returns 0x1122AB44, and no i_rvalid is generated for the store.
- Console backpressure: store 'H' (0x48) to 0x1000_0000 with con_ready=0 for 3 cycles then 1 -> con_valid high 4 cycles, d_gnt only in cycle 4, con_data=0x48, m_en never 1 for this access, while concurrent fetches are granted in cycles 1–3.
- Console load: load from 0x1000_0000 -> d_gnt same cycle, d_rvalid next cycle with d_rdata=0.
- Reset mid-operation: drive reset=0 in the cycle after a load grant -> d_rvalid stays 0, all outputs 0 after the edge; after reset=1, the first fetch to 0x0 is granted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the unified RAM arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_I,
    RESP_D
  } resp_owner_t;

  localparam int unsigned MEM_WORDS_DEF    = 65536;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam int unsigned MAX_DSTREAK_DEF  = 4;
  localparam int unsigned STRB_W           = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data RAM grant priority: data wins unless a waiting fetch has seen
// MAX_DSTREAK consecutive data grants.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam int unsigned   SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          starve;

  always_comb begin
    starve    = i_req_i && (dstreak_q == STREAK_MAX);
    grant_i_o = i_req_i && (!d_req_i || starve);
    grant_d_o = d_req_i && !starve;
    dstreak_d = dstreak_q;
    if (!i_req_i || grant_i_o) begin
      dstreak_d = '0;
    end else if (grant_d_o && (dstreak_q != STREAK_MAX)) begin
      dstreak_d = dstreak_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      dstreak_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store ports, with a console
// MMIO byte sink decoded off the data port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter int unsigned MAX_DSTREAK  = MAX_DSTREAK_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req,
  input  logic [AW-1:0]                 i_addr,
  output logic                          i_gnt,
  output logic                          i_rvalid,
  output logic [31:0]                   i_rdata,
  input  logic                          d_req,
  input  logic [STRB_W-1:0]             d_we,
  input  logic [AW-1:0]                 d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [31:0]                   d_rdata,
  output logic                          m_en,
  output logic [STRB_W-1:0]             m_we,
  output logic [$clog2(MEM_WORDS)-1:0]  m_addr,
  output logic [31:0]                   m_wdata,
  input  logic [31:0]                   m_rdata,
  output logic                          con_valid,
  output logic [7:0]                    con_data,
  input  logic                          con_ready
);

  localparam int unsigned   IW       = $clog2(MEM_WORDS);
  localparam logic [AW-3:0] CON_WORD = CONSOLE_ADDR[AW-1:2];

  logic        is_con, con_st, con_ld, fetch_req, ram_d_req;
  logic        grant_i, grant_d;
  logic        con_rd_q, con_rd_d;
  resp_owner_t owner_q, owner_d;
  logic        unused_addr;

  // Requests are masked by reset so every output reads zero while it is held.
  always_comb begin
    is_con    = (d_addr[AW-1:2] == CON_WORD);
    fetch_req = reset && i_req;
    ram_d_req = reset && d_req && !is_con;
    con_st    = reset && d_req && is_con && (d_we != '0);
    con_ld    = reset && d_req && is_con && (d_we == '0);
  end

  mem_arb_pick #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_pick (
    .clk      (clk),
    .rst_n_i  (reset),
    .i_req_i  (fetch_req),
    .d_req_i  (ram_d_req),
    .grant_i_o(grant_i),
    .grant_d_o(grant_d)
  );

  always_comb begin
    i_gnt     = grant_i;
    d_gnt     = grant_d || con_ld || (con_st && con_ready);
    con_valid = con_st;
    con_data  = con_st ? d_wdata[7:0] : '0;
    m_en      = grant_i || grant_d;
    m_we      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    owner_d   = RESP_NONE;
    con_rd_d  = con_ld;
    if (grant_d) begin
      m_we    = d_we;
      m_addr  = d_addr[IW+1:2];
      m_wdata = d_wdata;
      if (d_we == '0) owner_d = RESP_D;
    end else if (grant_i) begin
      m_addr  = i_addr[IW+1:2];
      owner_d = RESP_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q  <= RESP_NONE;
      con_rd_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      con_rd_q <= con_rd_d;
    end
  end

  always_comb begin
    i_rvalid = reset && (owner_q == RESP_I);
    d_rvalid = reset && ((owner_q == RESP_D) || con_rd_q);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = (reset && (owner_q == RESP_D)) ? m_rdata : '0;
  end

  // Alignment bits and out-of-range address bits are ignored (addresses wrap).
  always_comb unused_addr = ^{i_addr[AW-1:IW+2], i_addr[1:0], d_addr[1:0]};

endmodule
